task7_cordic_top: RTL and testbench



---
 rtl/task7_cordic_top.sv | 247 ++++++++++++++++++++++++
 tb/tb_task7_cordic_top.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/task7_cordic_top.sv
// task7_cordic_top: cos((x-128)/128) for an IEEE-754 single operand x.
// Flow: float -> Q8.14 -> Q1.20 angle -> 20-step CORDIC rotation -> float.
// Optional debug taps (result1..result8, enable1..enable9) are driven only when
// CORDIC_DEBUG_EN is defined; otherwise those ports read 0.
module task7_cordic_top (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        start,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] result1,
    output logic [31:0] result2,
    output logic [31:0] result3,
    output logic [31:0] result4,
    output logic [21:0] result5,
    output logic [21:0] result6,
    output logic [31:0] result7,
    output logic [31:0] result8,
    output logic        enable1,
    output logic        enable2,
    output logic        enable3,
    output logic        enable4,
    output logic        enable5,
    output logic        enable6,
    output logic        enable7,
    output logic        enable8,
    output logic        enable9
);

    localparam int unsigned FW    = 22;
    localparam int unsigned ITERS = 20;
    localparam logic signed [FW-1:0] K_INIT = 22'sd636751;

    // One-hot encoding so each state bit doubles as its enable tap.
    typedef enum logic [8:0] {
        S_IDLE      = 9'b0_0000_0001,
        S_CAPTURE   = 9'b0_0000_0010,
        S_CONVERT   = 9'b0_0000_0100,
        S_ANGLE     = 9'b0_0000_1000,
        S_INIT      = 9'b0_0001_0000,
        S_ITERATE   = 9'b0_0010_0000,
        S_NORMALIZE = 9'b0_0100_0000,
        S_PACK      = 9'b0_1000_0000,
        S_DONE      = 9'b1_0000_0000
    } state_t;

    state_t                 state_q;
    logic [31:0]            data_q;
    logic [FW-1:0]          xfix_q;
    logic signed [FW-1:0]   angle_q;
    logic signed [FW-1:0]   x_q, y_q, z_q;
    logic [4:0]             iter_q;
    logic [FW-1:0]          fin_q;
    logic [4:0]             lead_q;
    logic                   done_q;
    logic [31:0]            result_q;

    logic [FW-1:0]          xfix_d;
    logic signed [FW-1:0]   angle_d;
    logic signed [FW-1:0]   x_d, y_d, z_d;
    logic signed [FW-1:0]   x_sh, y_sh;
    logic signed [FW-1:0]   atan_c;
    logic [4:0]             lead_d;
    logic [31:0]            pack_d;
    logic [7:0]             exp_c;
    logic [4:0]             sh_c;
    logic                   nonpos_c;

    // Float to unsigned Q8.14 with truncation, clamping and underflow to zero.
    always_comb begin
        xfix_d = '0;
        exp_c  = data_q[30:23];
        sh_c   = 5'(exp_c - 8'd113);
        if (data_q[31] || (exp_c == 8'd0)) begin
            xfix_d = '0;
        end else if (exp_c >= 8'd135) begin
            xfix_d = '1;
        end else if (exp_c < 8'd113) begin
            xfix_d = '0;
        end else begin
            xfix_d = 22'({1'b1, data_q[22:0]} >> (5'd23 - sh_c));
        end
    end

    // Centre the operand on 128 and halve it: Q8.14 -> signed Q1.20.
    always_comb begin
        angle_d = 22'(({1'b0, xfix_q} - 23'd2097152) >> 1);
    end

    // atan(2^-i) in Q1.20, rounded to nearest.
    always_comb begin
        case (iter_q)
            5'd0:    atan_c = 22'sd823550;
            5'd1:    atan_c = 22'sd486170;
            5'd2:    atan_c = 22'sd256879;
            5'd3:    atan_c = 22'sd130396;
            5'd4:    atan_c = 22'sd65451;
            5'd5:    atan_c = 22'sd32757;
            5'd6:    atan_c = 22'sd16383;
            5'd7:    atan_c = 22'sd8192;
            5'd8:    atan_c = 22'sd4096;
            5'd9:    atan_c = 22'sd2048;
            5'd10:   atan_c = 22'sd1024;
            5'd11:   atan_c = 22'sd512;
            5'd12:   atan_c = 22'sd256;
            5'd13:   atan_c = 22'sd128;
            5'd14:   atan_c = 22'sd64;
            5'd15:   atan_c = 22'sd32;
            5'd16:   atan_c = 22'sd16;
            5'd17:   atan_c = 22'sd8;
            5'd18:   atan_c = 22'sd4;
            5'd19:   atan_c = 22'sd2;
            default: atan_c = 22'sd0;
        endcase
    end

    // One CORDIC micro-rotation; direction follows the sign of the residual angle.
    always_comb begin
        x_sh = x_q >>> iter_q;
        y_sh = y_q >>> iter_q;
        if (!z_q[FW-1]) begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_c;
        end else begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_c;
        end
    end

    // Leading-one position of the final X; bit 21 is the sign so p <= 20.
    always_comb begin
        lead_d = '0;
        for (int b = 0; b < 21; b++) begin
            if (x_q[b]) lead_d = 5'(b);
        end
    end

    // Pack Q1.20 into single precision; the hidden one shifts out of the 23-bit field.
    always_comb begin
        nonpos_c = fin_q[FW-1] || (fin_q == '0);
        pack_d   = {1'b0, 8'(8'd107 + 8'(lead_q)), 23'(fin_q[20:0]) << (5'd23 - lead_q)};
        if (nonpos_c) pack_d = 32'h0000_0000;
    end

    // Control sequence and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            data_q   <= '0;
            xfix_q   <= '0;
            angle_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            iter_q   <= '0;
            fin_q    <= '0;
            lead_q   <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    data_q  <= data;
                    state_q <= S_CONVERT;
                end
                S_CONVERT: begin
                    xfix_q  <= xfix_d;
                    state_q <= S_ANGLE;
                end
                S_ANGLE: begin
                    angle_q <= angle_d;
                    state_q <= S_INIT;
                end
                S_INIT: begin
                    x_q     <= K_INIT;
                    y_q     <= '0;
                    z_q     <= angle_q;
                    iter_q  <= '0;
                    state_q <= S_ITERATE;
                end
                S_ITERATE: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (iter_q == 5'(ITERS - 1)) begin
                        state_q <= S_NORMALIZE;
                    end else begin
                        iter_q <= iter_q + 5'd1;
                    end
                end
                S_NORMALIZE: begin
                    fin_q   <= x_q;
                    lead_q  <= lead_d;
                    state_q <= S_PACK;
                end
                S_PACK: begin
                    result_q <= pack_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done   = done_q;
    assign result = result_q;

`ifdef CORDIC_DEBUG_EN
    logic [8:0] state_bits;
    assign state_bits = state_q;

    // Debug taps straight from the stage registers.
    assign result1 = data_q;
    assign result2 = {{10{x_q[FW-1]}}, x_q};
    assign result3 = {{10{y_q[FW-1]}}, y_q};
    assign result4 = {{10{z_q[FW-1]}}, z_q};
    assign result5 = xfix_q;
    assign result6 = angle_q;
    assign result7 = {27'd0, iter_q};
    assign result8 = {10'd0, fin_q};
    assign {enable9, enable8, enable7, enable6, enable5,
            enable4, enable3, enable2, enable1} = state_bits;
`else
    assign result1 = '0;
    assign result2 = '0;
    assign result3 = '0;
    assign result4 = '0;
    assign result5 = '0;
    assign result6 = '0;
    assign result7 = '0;
    assign result8 = '0;
    assign {enable9, enable8, enable7, enable6, enable5,
            enable4, enable3, enable2, enable1} = 9'd0;
`endif

endmodule

// File: tb/tb_task7_cordic_top.sv
// Bench for task7_cordic_top: scoreboard of expected cos results and done timing.
module tb_task7_cordic_top;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data;
    logic        start;
    logic        done;
    logic [31:0] result;
    logic [31:0] result1, result2, result3, result4, result7, result8;
    logic [21:0] result5, result6;
    logic        enable1, enable2, enable3, enable4, enable5;
    logic        enable6, enable7, enable8, enable9;
    logic [8:0]  en_vec;

    task7_cordic_top dut (
        .clk(clk), .reset(reset), .data(data), .start(start),
        .done(done), .result(result),
        .result1(result1), .result2(result2), .result3(result3), .result4(result4),
        .result5(result5), .result6(result6), .result7(result7), .result8(result8),
        .enable1(enable1), .enable2(enable2), .enable3(enable3), .enable4(enable4),
        .enable5(enable5), .enable6(enable6), .enable7(enable7), .enable8(enable8),
        .enable9(enable9)
    );

    always #5 clk = ~clk;

    assign en_vec = {enable9, enable8, enable7, enable6, enable5,
                     enable4, enable3, enable2, enable1};

    int     n_total = 0;
    int     n_bad   = 0;
    int     done_cnt = 0;
    longint cyc = 0;
    longint last_units = 0;

    longint      exp_units_q[$];
    longint      exp_cyc_q[$];
    longint      exp_xf_q[$];
    longint      exp_ang_q[$];
    logic [31:0] exp_data_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        longint diff;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        n_total++;
        if (diff > tol) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
                     tag, got, got, exp, exp, tol);
        end
    endtask

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r * 0.5;
        return r;
    endfunction

    // Reference float -> Q8.14 conversion from the real value of the operand.
    function automatic longint model_xfix(input logic [31:0] f);
        int  e;
        real v;
        e = int'(f[30:23]);
        if (f[31] || e == 0) return 0;
        if (e == 255) return 4194303;
        v = (1.0 + real'(f[22:0]) / 8388608.0) * pow2(e - 127);
        if (v >= 256.0) return 4194303;
        if (v < pow2(-14)) return 0;
        return longint'($floor(v * 16384.0));
    endfunction

    // DUT float result expressed in units of 2^-20.
    function automatic longint res_units(input logic [31:0] r);
        longint m;
        int     e;
        if (r[30:0] == 31'd0) return 0;
        e = int'(r[30:23]);
        m = longint'({1'b1, r[22:0]});
        if (e >= 130) return m << (e - 130);
        return m >> (130 - e);
    endfunction

    // Builds the float whose value is exactly k * 2^-14.
    function automatic logic [31:0] q14_to_float(input int unsigned k);
        int     p;
        longint w;
        p = 0;
        for (int b = 0; b < 22; b++) if (k[b]) p = b;
        w = longint'(k) << (23 - p);
        return {1'b0, 8'(113 + p), w[22:0]};
    endfunction

    task automatic push_job(input logic [31:0] f, input longint at_cyc);
        longint xf, ang;
        real    c;
        xf  = model_xfix(f);
        ang = (xf - 2097152) >>> 1;
        c   = $cos(real'(ang) / 1048576.0);
        exp_units_q.push_back(longint'($rtoi(c * 1048576.0 + 0.5)));
        exp_cyc_q.push_back(at_cyc);
        exp_xf_q.push_back(xf);
        exp_ang_q.push_back(ang);
        exp_data_q.push_back(f);
    endtask

    task automatic flush_jobs();
        exp_units_q.delete();
        exp_cyc_q.delete();
        exp_xf_q.delete();
        exp_ang_q.delete();
        exp_data_q.delete();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_units_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        check("drain_pending", exp_units_q.size(), 0, 0);
        flush_jobs();
    endtask

    task automatic run_job(input logic [31:0] f);
        @(negedge clk); #1;
        data  = f;
        start = 1'b1;
        push_job(f, cyc + 27);
        @(negedge clk); #1;
        start = 1'b0;
        drain(40);
        repeat (4) @(negedge clk);
        check("result_hold", res_units(result), last_units, 8);
    endtask

    // Output monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        longint eu, ec, exf, eang;
        logic [31:0] ed;
        if (!reset) begin
`ifdef CORDIC_DEBUG_EN
            check("onehot", $countones(en_vec), 1, 0);
`endif
            if (done) begin
                done_cnt++;
                if (exp_units_q.size() == 0) begin
                    check("spurious_done", 1, 0, 0);
                end else begin
                    eu   = exp_units_q.pop_front();
                    ec   = exp_cyc_q.pop_front();
                    exf  = exp_xf_q.pop_front();
                    eang = exp_ang_q.pop_front();
                    ed   = exp_data_q.pop_front();
                    last_units = eu;
                    check("latency", cyc, ec, 0);
                    check("sign", result[31], 0, 0);
                    check("cos", res_units(result), eu, 8);
`ifdef CORDIC_DEBUG_EN
                    check("en9_at_done", enable9, 1, 0);
                    check("dbg_operand", result1, ed, 0);
                    check("dbg_xfix", result5, exf, 0);
                    check("dbg_angle", result6, eang & 64'h3F_FFFF, 0);
                    check("dbg_final_x", result8, eu, 8);
`else
                    check("dbg_tied", |{result1, result2, result3, result4, result5,
                                        result6, result7, result8, en_vec}, 0, 0);
`endif
                end
            end
        end
    end

    logic [31:0] vecs [15] = '{
        32'h437F0000, 32'h43000000, 32'h00000000, 32'hC2C80000, 32'h7F800000,
        32'h42800000, 32'h3F800000, 32'h43488000, 32'h358637BD, 32'h43960000,
        32'h7FC00000, 32'h80000000, 32'h00400000, 32'h38800000, 32'h437FFFFF
    };

    initial begin
        longint a;
        int     d0;
        reset = 1'b1;
        start = 1'b0;
        data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        reset = 1'b0;
        check("rst_done", done, 0, 0);
        check("rst_result", result, 0, 0);
`ifdef CORDIC_DEBUG_EN
        check("rst_en_idle", en_vec, 1, 0);
`else
        check("rst_en_tied", en_vec, 0, 0);
`endif
        check("rst_dbg", |{result1, result2, result3, result4, result5,
                           result6, result7, result8}, 0, 0);

        foreach (vecs[i]) run_job(vecs[i]);
        for (int i = 0; i < 6; i++) run_job(q14_to_float($urandom_range(1, 4194303)));

        // Extra start pulse while iterating must be ignored.
        @(negedge clk); #1;
        data  = 32'h43200000;
        start = 1'b1;
        push_job(32'h43200000, cyc + 27);
        d0 = done_cnt;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 data = 32'h42000000; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        drain(40);
        repeat (35) @(negedge clk);
        check("ignored_start", done_cnt - d0, 1, 0);

        // Reset in the middle of ITERATE aborts the job.
        @(negedge clk); #1;
        data  = 32'h42C80000;
        start = 1'b1;
        d0 = done_cnt;
        @(negedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("midrst_done", done, 0, 0);
        check("midrst_result", result, 0, 0);
`ifdef CORDIC_DEBUG_EN
        check("midrst_idle", en_vec, 1, 0);
`endif
        #1 reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrst_nodone", done_cnt - d0, 0, 0);

        // start held high: two jobs, done pulses 28 cycles apart.
        @(negedge clk); #1;
        a = cyc;
        data  = 32'h43400000;
        start = 1'b1;
        d0 = done_cnt;
        push_job(32'h43400000, a + 27);
        push_job(32'h43400000, a + 55);
        for (int i = 0; i < 40 && cyc < a + 29; i++) begin
            @(negedge clk); #1;
        end
        start = 1'b0;
        drain(80);
        repeat (35) @(negedge clk);
        check("b2b_count", done_cnt - d0, 2, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
